// File: rtl/register_resetless.sv
// Single-word holding register: rising-edge load under wrEn, asynchronous active-high
// clear to RESET_VALUE. dataOut always reflects the stored flops, never dataIn directly.
module register_resetless #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] INIT_VALUE  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);

    // Declaration initialiser supplies the power-up contents before any reset or load.
    logic [WIDTH-1:0] data_q = INIT_VALUE;
    logic [WIDTH-1:0] data_d;

    // Ternary (not if/else) so an X on wrEn propagates into the stored word.
    always_comb begin
        data_d = wrEn ? dataIn : data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign dataOut = data_q;

endmodule

// File: tb/tb_register_resetless.sv
// Randomised and directed checks of register_resetless at widths 32, 7, 3 (non-zero
// reset value) and 1, against a per-instance expected-value model.
module tb_register_resetless;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en32 = 1'b0, en7 = 1'b0, en3 = 1'b0, en1 = 1'b0;
    logic [31:0] d32 = '0;
    logic [6:0]  d7 = '0;
    logic [2:0]  d3 = '0;
    logic        d1 = 1'b0;
    logic [31:0] q32;
    logic [6:0]  q7;
    logic [2:0]  q3;
    logic        q1;

    logic [31:0] exp32 = '0;
    logic [6:0]  exp7 = '0;
    logic [2:0]  exp3 = '0;
    logic        exp1 = 1'b0;

    localparam logic [2:0] RV3 = 3'h5;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_resetless #(32) u32 (
        .clk(clk), .reset(rst), .wrEn(en32), .dataIn(d32), .dataOut(q32));
    register_resetless #(.WIDTH(7)) u7 (
        .clk(clk), .reset(rst), .wrEn(en7), .dataIn(d7), .dataOut(q7));
    register_resetless #(.WIDTH(3), .RESET_VALUE(RV3)) u3 (
        .clk(clk), .reset(rst), .wrEn(en3), .dataIn(d3), .dataOut(q3));
    register_resetless #(.WIDTH(1)) u1 (
        .clk(clk), .reset(rst), .wrEn(en1), .dataIn(d1), .dataOut(q1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w32"}, q32, exp32);
        check({tag, ".w7"}, {25'd0, q7}, {25'd0, exp7});
        check({tag, ".w3"}, {29'd0, q3}, {29'd0, exp3});
        check({tag, ".w1"}, {31'd0, q1}, {31'd0, exp1});
    endtask

    // Model: at a rising edge with reset low, an enabled register takes its input.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) begin
            if (en32) exp32 = d32;
            if (en7)  exp7  = d7;
            if (en3)  exp3  = d3;
            if (en1)  exp1  = d1;
        end
        #1;
        check_all(tag);
    endtask

    // Mid-cycle reset pulse: outputs must clear before any clock edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp32 = '0; exp7 = '0; exp3 = RV3; exp1 = 1'b0;
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check_all("powerup");

        // Load then asynchronous clear
        @(negedge clk); en32 = 1'b1; d32 = 32'hDEADBEEF;
        step("load_deadbeef");
        en32 = 1'b0;
        reset_pulse("async_clear");

        // Load / hold
        @(negedge clk); en32 = 1'b1; d32 = 32'h12345678;
        step("load_12345678");
        @(negedge clk); en32 = 1'b0; d32 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) step("hold");

        // Continuous enable, width 7; output must not follow dataIn before the edge
        en7 = 1'b1;
        begin
            logic [6:0] seq [3];
            seq[0] = 7'h01; seq[1] = 7'h7F; seq[2] = 7'h40;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); d7 = seq[i];
                #1;
                check("w7_no_passthru", {25'd0, q7}, {25'd0, exp7});
                step("w7_seq");
            end
        end
        en7 = 1'b0;

        // Reset held across edges beats wrEn
        @(negedge clk); rst = 1'b1; en32 = 1'b1; d32 = 32'hAAAAAAAA;
        exp32 = '0; exp7 = '0; exp3 = RV3; exp1 = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_priority");
        @(negedge clk); rst = 1'b0;
        step("rst_release_load");
        en32 = 1'b0;

        // Non-zero reset value, width 3
        @(negedge clk); en3 = 1'b1; d3 = 3'h2;
        step("w3_load2");
        en3 = 1'b0;
        reset_pulse("w3_reset");
        @(negedge clk); en3 = 1'b1; d3 = 3'h7;
        step("w3_load7");
        en3 = 1'b0;

        // Width 1: toggle with enable, then hold
        en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); d1 = ~d1;
            step("w1_toggle");
        end
        en1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); d1 = ~d1;
            step("w1_hold");
        end

        // Random traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) reset_pulse("rnd_reset");
            else @(negedge clk);
            en32 = 1'($urandom); en7 = 1'($urandom);
            en3  = 1'($urandom); en1 = 1'($urandom);
            d32  = $urandom;     d7  = 7'($urandom);
            d3   = 3'($urandom); d1  = 1'($urandom);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
